// File: rtl/full_adder_bist.sv
// Built-in self-test initiator for a 3-input full adder: sweeps codes 000..111,
// waits a programmable settle time per code, checks sum/carry and reports results.
module full_adder_bist #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [2:0] tv_out,
    input  logic       sum_in,
    input  logic       carry_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_count,
    output logic       fail_valid,
    output logic [2:0] first_fail_code
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CODE_W = 3;
    localparam int unsigned FC_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [CNT_W-1:0]    r_cnt;
    logic [CODE_W-1:0]   r_code;
    logic [CODE_W-1:0]   r_tv_out;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [FC_W-1:0]     r_fail_count;
    logic                r_fail_valid;
    logic [CODE_W-1:0]   r_first_fail_code;

    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CODE_W-1:0]   w_code_nxt;
    logic [CODE_W-1:0]   w_tv_out_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_pass_nxt;
    logic [FC_W-1:0]     w_fail_count_nxt;
    logic                w_fail_valid_nxt;
    logic [CODE_W-1:0]   w_first_fail_code_nxt;

    logic                w_exp_sum;
    logic                w_exp_carry;
    logic                w_mismatch;

    // Reference full-adder response for the code currently under test
    assign w_exp_sum   = ^r_code;
    assign w_exp_carry = (r_code[2] & r_code[1]) | (r_code[2] & r_code[0]) | (r_code[1] & r_code[0]);
    assign w_mismatch  = (r_state == S_CHECK) && ({carry_in, sum_in} != {w_exp_carry, w_exp_sum});

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_next = S_SETTLE;
            S_SETTLE: if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) w_next = S_CHECK;
            S_CHECK:  w_next = (r_code == 3'b111) ? S_DONE : S_SETTLE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Next values of the datapath and the registered outputs
    always_comb begin
        w_cnt_nxt             = r_cnt;
        w_code_nxt            = r_code;
        w_pass_nxt            = r_pass;
        w_fail_count_nxt      = r_fail_count;
        w_fail_valid_nxt      = r_fail_valid;
        w_first_fail_code_nxt = r_first_fail_code;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_cnt_nxt             = '0;
                    w_code_nxt            = '0;
                    w_pass_nxt            = 1'b0;
                    w_fail_count_nxt      = '0;
                    w_fail_valid_nxt      = 1'b0;
                    w_first_fail_code_nxt = '0;
                end
            end
            S_SETTLE: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            S_CHECK: begin
                if (w_mismatch) begin
                    w_fail_count_nxt = r_fail_count + FC_W'(1);
                    if (!r_fail_valid) begin
                        w_first_fail_code_nxt = r_code;
                        w_fail_valid_nxt      = 1'b1;
                    end
                end
                if (r_code == 3'b111) begin
                    // Pass uses the count including this final compare
                    w_pass_nxt = (w_fail_count_nxt == '0);
                end else begin
                    w_code_nxt = r_code + CODE_W'(1);
                    w_cnt_nxt  = '0;
                end
            end
            default: begin
            end
        endcase
        w_busy_nxt   = (w_next == S_SETTLE) || (w_next == S_CHECK);
        w_done_nxt   = (w_next == S_DONE);
        w_tv_out_nxt = w_busy_nxt ? w_code_nxt : '0;
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt             <= '0;
            r_code            <= '0;
            r_tv_out          <= '0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_fail_count      <= '0;
            r_fail_valid      <= 1'b0;
            r_first_fail_code <= '0;
        end else begin
            r_cnt             <= w_cnt_nxt;
            r_code            <= w_code_nxt;
            r_tv_out          <= w_tv_out_nxt;
            r_busy            <= w_busy_nxt;
            r_done            <= w_done_nxt;
            r_pass            <= w_pass_nxt;
            r_fail_count      <= w_fail_count_nxt;
            r_fail_valid      <= w_fail_valid_nxt;
            r_first_fail_code <= w_first_fail_code_nxt;
        end
    end

    assign tv_out          = r_tv_out;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign fail_count      = r_fail_count;
    assign fail_valid      = r_fail_valid;
    assign first_fail_code = r_first_fail_code;

endmodule
